trng_sampler: RTL and testbench
===============================

Name: trng_sampler

Overview:
- Parametrised successor to the single-ring-oscillator TRNG output.
- Samples NUM_CH free-running oscillator channels and XOR-combines them into one raw bit per clock.
- Optionally applies von Neumann debiasing, runs a repetition-count health test and packs bits into OUT_W-bit words.
- Delivers words over a valid/ready interface, e.g. to the existing UART transmitter.

Parameters:
- NUM_CH, 4, number of oscillator channels (1..8).
- OUT_W, 8, output word width (2..16).
- SYNC_STAGES, 2, synchroniser flops per channel (≥2).
- DEBIAS, 1, 1 = von Neumann debiasing, 0 = raw bits passed through.
- WARMUP_CYCLES, 16, cycles discarded after enable (≥1).
- REP_LIMIT, 32, consecutive identical raw bits that trip the health test (≥2).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, run request.
- osc_in, input, NUM_CH, asynchronous oscillator outputs.
- osc_en, output, NUM_CH, per-channel oscillator enable, all bits equal.
- data_out, output, OUT_W, random word.
- data_valid, output, 1, data_out holds an undelivered word.
- data_ready, input, 1, consumer accepts the word.
- health_fail, output, 1, sticky health-test failure.
- busy, output, 1, state is WARMUP or RUN.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; all state clears on the clk edge where rst=1.
- Reset values: osc_en=0, data_out=0, data_valid=0, health_fail=0, busy=0, state=IDLE. Synchroniser, pair, repetition and assembly registers are 0.
- Synchroniser: each osc_in bit passes through SYNC_STAGES flops. raw_q is a register holding the XOR of all synchronised bits, so it lags osc_in by SYNC_STAGES+1 cycles.
- FSM states: IDLE, WARMUP, RUN, FAIL.
- IDLE: osc_en=0. en=1 goes to WARMUP and loads the warmup counter.
- WARMUP: osc_en all-ones. Each cycle is counted; raw bits are ignored and the health test is idle. After WARMUP_CYCLES cycles, goes to RUN. en=0 returns to IDLE.
- RUN: osc_en all-ones. Each cycle raw_q feeds the health test and the debiaser. en=0 goes to IDLE. Health trip goes to FAIL; FAIL takes priority over en=0 in the same cycle.
- FAIL: osc_en=0, health_fail=1. Assembly clears, data_valid forced 0 and the pending word is discarded. Only rst exits FAIL.
- Leaving RUN for IDLE: pair state, repetition counter and bit count clear. A pending valid word stays valid until accepted.
- Health test: a counter tracks consecutive equal raw_q values. The first RUN cycle starts the counter at 1. A change of value resets it to 1. Reaching REP_LIMIT trips the test; health_fail asserts in the same cycle FAIL is entered, i.e. the cycle after the REP_LIMIT-th equal bit.
- Debias (DEBIAS=1): raw bits are taken in non-overlapping pairs (first, second).
  - 01 emits 0; 10 emits 1.
  - 00 and 11 emit nothing.
  - Pair phase resets when the FSM enters RUN.
- Debias off (DEBIAS=0): every RUN raw bit is emitted.
- Assembly: each emitted bit shifts in as sr <= {sr[OUT_W-2:0], bit}, so the first bit ends at the MSB, and bit_cnt increments.
  - When the OUT_W-th bit arrives and the output buffer is free (data_valid=0, or data_valid&data_ready this cycle), the next cycle shows the completed word on data_out with data_valid=1, and bit_cnt returns to 0.
  - Buffer full (data_valid=1, data_ready=0) when a word completes: the completed word is held in sr. Further emitted bits are dropped, and the word loads on the first cycle the buffer frees.
- Handshake: a transfer occurs on a cycle with data_valid&data_ready. After a transfer, data_valid drops the next cycle unless a new word loads on the same edge; back-to-back delivery keeps data_valid=1. data_out is stable while data_valid=1 and data_ready=0.
- busy = (state==WARMUP) | (state==RUN).

Test Plan:
- Reset/idle: apply rst for 2 cycles with en=0. Outputs match reset values; osc_en=0 for 50 cycles.
- Warmup timing: NUM_CH=4, WARMUP_CYCLES=16, en=1 at cycle 0. osc_en=4'hF from cycle 1; state is RUN from cycle 17. No bits are emitted before cycle 17.
- Debiased word: NUM_CH=1, DEBIAS=1, OUT_W=8. Drive the raw sequence of pairs 10,01,10,10,00,01,11,10,01,10 after warmup. Pairs 00 and 11 are discarded, so data_out=8'hB5 with data_valid=1 exactly one cycle after the last pair bit.
- Backpressure: data_ready=0 while two words complete. The first word is held stable and the second is held in sr with later bits dropped. Raising data_ready for 1 cycle delivers word 1, and word 2 appears the next cycle with data_valid kept high.
- Health trip: NUM_CH=2, both osc_in held at 1 so raw=0, REP_LIMIT=32. health_fail rises 32 cycles after RUN entry plus 1. Then osc_en=0 and data_valid=0, en toggling has no effect, and rst clears everything.
- en drop mid-word: deassert en after 5 emitted bits. FSM goes to IDLE and bit_cnt=0. Re-enabling repeats warmup, and the next word contains only bits from the new run.

Source files
------------

// File: rtl/trng_sampler.sv
// Multi-channel ring-oscillator TRNG sampler: synchronise and XOR the channels,
// optionally von Neumann debias, run a repetition-count health test, pack into words.

module trng_sync_ch #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic osc,
   output logic sync
);
   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (rst) ff <= '0;
      else     ff <= {ff[SYNC_STAGES-2:0], osc};
   end

   assign sync = ff[SYNC_STAGES-1];
endmodule

module trng_sampler #(
   parameter int NUM_CH        = 4,
   parameter int OUT_W         = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int DEBIAS        = 1,
   parameter int WARMUP_CYCLES = 16,
   parameter int REP_LIMIT     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH-1:0] osc_in,
   output logic [NUM_CH-1:0] osc_en,
   output logic [OUT_W-1:0]  data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              health_fail,
   output logic              busy
);
   localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
   localparam int RW = $clog2(REP_LIMIT + 1);
   localparam int BW = $clog2(OUT_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAIL} state_t;
   state_t state, state_nxt;

   logic [NUM_CH-1:0] sync_bits;
   logic              raw_q;
   logic [WW-1:0]     warm_cnt;
   logic [RW-1:0]     rep_cnt, rep_cnt_run;
   logic              last_raw;
   logic              pair_have, pair_first;
   logic [OUT_W-1:0]  sr, sr_shift;
   logic [BW-1:0]     bit_cnt;
   logic              in_run, trip, emit_v, emit_b;
   logic              buf_free, held, leave_run;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      trng_sync_ch #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk  (clk),
         .rst  (rst),
         .osc  (osc_in[c]),
         .sync (sync_bits[c])
      );
   end

   // rep_cnt==0 marks "no previous bit yet", so the first RUN sample counts as 1
   always_comb begin
      in_run      = (state == S_RUN);
      rep_cnt_run = (rep_cnt == '0 || raw_q != last_raw) ? RW'(1) : rep_cnt + RW'(1);
      trip        = in_run && (rep_cnt_run == RW'(REP_LIMIT));
      if (DEBIAS != 0) begin
         emit_v = in_run && pair_have && (pair_first != raw_q);
         emit_b = pair_first;
      end else begin
         emit_v = in_run;
         emit_b = raw_q;
      end
      sr_shift = {sr[OUT_W-2:0], emit_b};
      buf_free = !data_valid || data_ready;
      held     = (bit_cnt == BW'(OUT_W));
   end

   always_comb begin
      state_nxt = state;
      leave_run = 1'b0;
      unique case (state)
         S_IDLE:   if (en) state_nxt = S_WARMUP;
         S_WARMUP: begin
            if (!en)                  state_nxt = S_IDLE;
            else if (warm_cnt == '0)  state_nxt = S_RUN;
         end
         S_RUN: begin
            if (trip) state_nxt = S_FAIL;
            else if (!en) begin
               state_nxt = S_IDLE;
               leave_run = 1'b1;
            end
         end
         S_FAIL:   state_nxt = S_FAIL;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   assign busy        = (state == S_WARMUP) || (state == S_RUN);
   assign health_fail = (state == S_FAIL);
   assign osc_en      = {NUM_CH{busy}};

   always_ff @(posedge clk) begin
      if (rst) begin
         raw_q      <= 1'b0;
         warm_cnt   <= '0;
         rep_cnt    <= '0;
         last_raw   <= 1'b0;
         pair_have  <= 1'b0;
         pair_first <= 1'b0;
         sr         <= '0;
         bit_cnt    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         raw_q <= ^sync_bits;

         if (state == S_IDLE)
            warm_cnt <= WW'(WARMUP_CYCLES - 1);
         else if (state == S_WARMUP && warm_cnt != '0)
            warm_cnt <= warm_cnt - WW'(1);

         // pair phase and run length only live inside RUN
         if (in_run) begin
            rep_cnt   <= rep_cnt_run;
            last_raw  <= raw_q;
            pair_have <= ~pair_have;
            if (!pair_have) pair_first <= raw_q;
         end else begin
            rep_cnt   <= '0;
            pair_have <= 1'b0;
         end

         if (data_valid && data_ready) data_valid <= 1'b0;

         // a completed word parks in sr (bit_cnt==OUT_W) until the buffer frees
         if (held) begin
            if (buf_free) begin
               data_out   <= sr;
               data_valid <= 1'b1;
               bit_cnt    <= '0;
            end
         end else if (emit_v) begin
            sr <= sr_shift;
            if (bit_cnt == BW'(OUT_W - 1)) begin
               if (buf_free) begin
                  data_out   <= sr_shift;
                  data_valid <= 1'b1;
                  bit_cnt    <= '0;
               end else begin
                  bit_cnt <= BW'(OUT_W);
               end
            end else begin
               bit_cnt <= bit_cnt + BW'(1);
            end
         end

         if (state_nxt == S_FAIL) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            sr         <= '0;
            bit_cnt    <= '0;
         end else if (leave_run) begin
            sr      <= '0;
            bit_cnt <= '0;
         end
      end
   end
endmodule

// File: tb/tb_trng_sampler.sv
// Bench for trng_sampler: queue-based behavioural model checked every cycle,
// plus directed literal expectations for warmup, debiasing, backpressure, en drop and health trip.

module tb_trng_sampler;
   localparam int NUM_CH = 2;
   localparam int OUT_W  = 8;
   localparam int SS     = 2;
   localparam int DEBIAS = 1;
   localparam int WARM   = 16;
   localparam int REP    = 32;
   localparam int OFS    = WARM + 1 - (SS + 1);

   logic              clk = 1'b0;
   logic              rst, en, data_ready;
   logic [NUM_CH-1:0] osc_in;
   logic [NUM_CH-1:0] osc_en;
   logic [OUT_W-1:0]  data_out;
   logic              data_valid, health_fail, busy;

   int n_chk = 0;
   int n_err = 0;

   trng_sampler #(
      .NUM_CH(NUM_CH), .OUT_W(OUT_W), .SYNC_STAGES(SS), .DEBIAS(DEBIAS),
      .WARMUP_CYCLES(WARM), .REP_LIMIT(REP)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .osc_in(osc_in), .osc_en(osc_en),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .health_fail(health_fail), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // model: 0 idle, 1 warmup, 2 run, 3 fail
   int               m_state, m_warm, m_run_len;
   bit               m_last, m_have, m_first, m_dv;
   logic [OUT_W-1:0] m_do;
   bit               q[$];
   bit               hist[$];

   task automatic model_step();
      bit raw, free, e_v, e_b;
      logic [OUT_W-1:0] w;
      if (rst) begin
         m_state = 0; m_warm = 0; m_run_len = 0; m_last = 0; m_have = 0; m_first = 0;
         m_dv = 0; m_do = '0; q = {}; hist = {};
         repeat (SS + 1) hist.push_back(1'b0);
         return;
      end
      raw = hist.pop_front();
      hist.push_back(^osc_in);
      if (m_state == 3) return;
      free = !m_dv || data_ready;
      if (m_dv && data_ready) m_dv = 0;
      e_v = 0; e_b = 0; w = '0;
      case (m_state)
         0: if (en) begin m_state = 1; m_warm = 0; end
         1: if (!en) m_state = 0;
            else begin
               m_warm++;
               if (m_warm == WARM) begin m_state = 2; m_have = 0; m_run_len = 0; end
            end
         default: begin
            m_run_len = (m_run_len == 0 || raw != m_last) ? 1 : m_run_len + 1;
            m_last = raw;
            if (DEBIAS != 0) begin
               if (!m_have) begin m_first = raw; m_have = 1; end
               else begin
                  m_have = 0;
                  if (m_first != raw) begin e_v = 1; e_b = m_first; end
               end
            end else begin
               e_v = 1; e_b = raw;
            end
            if (e_v && q.size() < OUT_W) q.push_back(e_b);
            if (q.size() == OUT_W && free) begin
               foreach (q[i]) w[OUT_W-1-i] = q[i];
               m_do = w; m_dv = 1; q = {};
            end
            if (m_run_len >= REP) begin
               m_state = 3; m_dv = 0; m_do = '0; q = {};
            end else if (!en) begin
               m_state = 0; q = {}; m_have = 0; m_run_len = 0;
            end
         end
      endcase
   endtask

   initial begin
      logic [NUM_CH-1:0] m_osc;
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         m_osc = (m_state == 1 || m_state == 2) ? '1 : '0;
         chk("osc_en",      32'(osc_en),      32'(m_osc));
         chk("busy",        32'(busy),        32'(m_state == 1 || m_state == 2));
         chk("health_fail", 32'(health_fail), 32'(m_state == 3));
         chk("data_valid",  32'(data_valid),  32'(m_dv));
         chk("data_out",    32'(data_out),    32'(m_do));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive_raw(input bit b);
      osc_in    = NUM_CH'($urandom);
      osc_in[0] = b ^ (^osc_in[NUM_CH-1:1]);
   endtask

   bit pat[36] = '{1,0, 0,1, 1,0, 1,0, 0,0, 0,1, 1,1, 1,0, 0,1, 1,0,
                   0,1, 0,1, 1,0, 1,0, 1,0, 1,0, 0,1, 0,1};

   initial begin
      rst = 1'b1; en = 1'b0; osc_in = '0; data_ready = 1'b0;
      repeat (2) tick();
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_valid",    32'(data_valid), 32'h0);
      chk("rst_hf",       32'(health_fail), 32'h0);
      chk("rst_busy",     32'(busy), 32'h0);
      chk("rst_osc_en",   32'(osc_en), 32'h0);
      rst = 1'b0;
      repeat (50) begin osc_in = NUM_CH'($urandom); tick(); end
      chk("idle_osc_en", 32'(osc_en), 32'h0);

      // warmup timing, debiased word 0xB5, then backpressure with 0x3C parked
      for (int r = 0; r <= 62; r++) begin
         if (r == 0)  chk("w0_osc_en", 32'(osc_en), 32'h0);
         if (r == 1)  chk("w1_osc_en", 32'(osc_en), 32'h3);
         if (r == 36) chk("db_valid_early", 32'(data_valid), 32'h0);
         if (r == 37) begin
            chk("db_valid", 32'(data_valid), 32'h1);
            chk("db_word",  32'(data_out), 32'hB5);
         end
         if (r == 60) chk("bp_word1", 32'(data_out), 32'hB5);
         if (r == 61) begin
            chk("bp_valid2", 32'(data_valid), 32'h1);
            chk("bp_word2",  32'(data_out), 32'h3C);
         end
         en = 1'b1;
         data_ready = (r == 60);
         if (r >= OFS && r < OFS + 36) drive_raw(pat[r-OFS]);
         else                          drive_raw(1'($urandom));
         tick();
      end

      // randomized run with en drops and ready stalls
      for (int i = 0; i < 3000; i++) begin
         if (en) begin if ($urandom_range(0, 199) == 0) en = 1'b0; end
         else if ($urandom_range(0, 9) == 0) en = 1'b1;
         osc_in     = NUM_CH'($urandom);
         data_ready = (i % 400 < 80) ? 1'b0 : ($urandom_range(0, 3) != 0);
         tick();
      end

      en = 1'b0; data_ready = 1'b1;
      repeat (5) tick();
      chk("drain_valid", 32'(data_valid), 32'h0);

      // en drop after five emitted ones; the next word must hold only new-run bits
      data_ready = 1'b0;
      for (int r = 0; r <= 64; r++) begin
         if (r == 28) chk("drop_busy", 32'(busy), 32'h0);
         if (r == 63) chk("drop_valid_early", 32'(data_valid), 32'h0);
         if (r == 64) begin
            chk("drop_valid", 32'(data_valid), 32'h1);
            chk("drop_word",  32'(data_out), 32'h00);
         end
         en = !(r >= 27 && r < 31);
         if (r >= OFS && r < OFS + 10)           drive_raw((r - OFS) % 2 == 0);
         else if (r >= 31 + OFS && r < 47 + OFS) drive_raw((r - 31 - OFS) % 2 == 1);
         else                                    drive_raw(1'($urandom));
         tick();
      end

      en = 1'b0; data_ready = 1'b1;
      repeat (3) tick();

      // health trip: both channels at 1 gives a constant raw 0
      for (int r = 0; r <= 49; r++) begin
         if (r == 48) chk("ht_hf_early", 32'(health_fail), 32'h0);
         if (r == 49) begin
            chk("ht_hf",     32'(health_fail), 32'h1);
            chk("ht_osc_en", 32'(osc_en), 32'h0);
            chk("ht_valid",  32'(data_valid), 32'h0);
         end
         en = 1'b1;
         osc_in = '1;
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         en = 1'($urandom); data_ready = 1'($urandom); osc_in = NUM_CH'($urandom);
         tick();
      end
      chk("ht_sticky", 32'(health_fail), 32'h1);

      rst = 1'b1; en = 1'b0;
      repeat (2) tick();
      chk("ht_rst_hf",   32'(health_fail), 32'h0);
      chk("ht_rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
